// File: rtl/host_launcher_pkg.sv
// host_launcher_pkg: shared state encoding and width constants for the host launcher.
package host_launcher_pkg;
  localparam int CYC_W = 16;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  typedef enum logic [3:0] {
    IDLE, PRST, LOAD, START_HI, START_LO, RB_ADDR, RB_HOLD, DONE, TIMEOUT
  } hl_state_t;
endpackage

// File: rtl/hl_watchdog.sv
// hl_watchdog: counts enabled cycles and flags the cycle on which LIMIT is reached.
module hl_watchdog
  import host_launcher_pkg::*;
#(
  parameter int LIMIT = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [CYC_W-1:0] cnt_q, cnt_d;
  assign expired = enable && cnt_q == CYC_W'(LIMIT - 1);
  always_comb begin
    cnt_d = clear ? '0 : (enable && !expired) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/host_launcher.sv
// host_launcher: resets, preloads, launches and reads back the processor over start/ack.
// HOST_LAUNCHER_WATCHDOG_EN adds a wait-for-ack watchdog ending in TIMEOUT.
module host_launcher
  import host_launcher_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int START_PULSE = 4,
  parameter int RB_BASE     = 0,
  parameter int RB_COUNT    = 4,
  parameter int WDOG_LIMIT  = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              proc_reset,
  output logic              start,
  input  logic              ack,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rb_valid,
  input  logic              rb_ready,
  output logic [DATA_W-1:0] rb_data,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [CYC_W-1:0]  cycles
);
  hl_state_t state_q, state_d;
  logic [CYC_W-1:0] cnt_q, cnt_d, idx_q, idx_d, cycles_q, cycles_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] rb_data_q, rb_data_d;
  logic wdog_exp, ld_fire;
`ifdef HOST_LAUNCHER_WATCHDOG_EN
  hl_watchdog #(.LIMIT(WDOG_LIMIT)) u_wdog (
    .clk(clk),
    .reset(reset),
    .clear(state_q != START_LO),
    .enable(state_q == START_LO),
    .expired(wdog_exp)
  );
  assign timeout = state_q == TIMEOUT;
`else
  assign wdog_exp = 1'b0;
  assign timeout = 1'b0;
`endif
  // Only LOAD drives the memory port combinationally; elsewhere the address is the readback flop.
  assign ld_fire    = state_q == LOAD && ld_valid;
  assign ld_ready   = state_q == LOAD;
  assign mem_we     = ld_fire;
  assign mem_addr   = ld_fire ? ld_addr : addr_q;
  assign mem_wdata  = ld_fire ? ld_data : '0;
  assign proc_reset = state_q == PRST;
  assign start      = state_q == START_HI;
  assign rb_valid   = state_q == RB_HOLD;
  assign rb_data    = rb_data_q;
  assign busy       = !(state_q inside {IDLE, DONE, TIMEOUT});
  assign done       = state_q == DONE;
  assign cycles     = cycles_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    cycles_d = cycles_q;
    addr_d = addr_q;
    rb_data_d = rb_data_q;
    case (state_q)
      IDLE, DONE, TIMEOUT: if (go) begin
        state_d = PRST;
        cnt_d = '0;
        cycles_d = '0;
      end
      PRST: begin
        cnt_d = cnt_q == CYC_W'(1) ? '0 : cnt_q + 1'b1;
        state_d = cnt_q == CYC_W'(1) ? LOAD : PRST;
      end
      LOAD: state_d = (ld_valid && ld_last) ? START_HI : LOAD;
      START_HI: begin
        cnt_d = cnt_q + 1'b1;
        state_d = cnt_q == CYC_W'(START_PULSE - 1) ? START_LO : START_HI;
      end
      START_LO: if (ack) begin
        state_d = RB_COUNT == 0 ? DONE : RB_ADDR;
        idx_d = '0;
        addr_d = ADDR_W'(RB_BASE);
      end else begin
        cycles_d = &cycles_q ? cycles_q : cycles_q + 1'b1;
        state_d = wdog_exp ? TIMEOUT : START_LO;
      end
      RB_ADDR: begin
        state_d = RB_HOLD;
        rb_data_d = mem_rdata;
      end
      RB_HOLD: if (rb_ready) begin
        state_d = idx_q == CYC_W'(RB_COUNT - 1) ? DONE : RB_ADDR;
        idx_d = idx_q + 1'b1;
        addr_d = addr_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      cycles_q <= '0;
      addr_q <= '0;
      rb_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      cycles_q <= cycles_d;
      addr_q <= addr_d;
      rb_data_q <= rb_data_d;
    end
  end
endmodule

// File: tb/tb_host_launcher.sv
// tb_host_launcher: directed checks of load, launch, ack timing, readback back-pressure and reset abort.
module tb_host_launcher;
  logic clk = 0, reset = 1, go = 0, ld_valid = 0, ld_last = 0, ack = 0, rb_ready = 0;
  logic [7:0] ld_addr = 0, ld_data = 0, mem_rdata, mem_addr, mem_wdata, rb_data;
  logic ld_ready, proc_reset, start, mem_we, rb_valid, busy, done, timeout;
  logic [15:0] cycles;
  logic [7:0] mem [256];
  logic [7:0] exp_rb [3] = '{8'h11, 8'h22, 8'h33};
  int n_chk = 0, n_pass = 0;
  host_launcher #(.START_PULSE(4), .RB_BASE(0), .RB_COUNT(3), .WDOG_LIMIT(20)) dut (
    .clk(clk), .reset(reset), .go(go), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last), .proc_reset(proc_reset),
    .start(start), .ack(ack), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .rb_valid(rb_valid), .rb_ready(rb_ready), .rb_data(rb_data),
    .busy(busy), .done(done), .timeout(timeout), .cycles(cycles)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask
  task automatic launch();
    go = 1;
    tick();
    go = 0;
    ack = 0;
    chk("prst_c1", proc_reset, 1);
    chk("go_clr_cycles", cycles, 0);
    chk("go_clr_done", done, 0);
    tick();
    chk("prst_c2", proc_reset, 1);
    tick();
    chk("prst_end", proc_reset, 0);
    chk("load_ready", ld_ready, 1);
    ld_valid = 1; ld_addr = 8'h07; ld_data = 8'h77; ld_last = 1;
    #1 chk("load1_we", mem_we, 1);
    tick();
    ld_valid = 0; ld_last = 0;
    chk("launch_start", start, 1);
    repeat (4) tick();
    chk("launch_start_lo", start, 0);
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_prst", proc_reset, 0);
    chk("rst_start", start, 0);
    chk("rst_cycles", cycles, 0);
    chk("rst_rbv", rb_valid, 0);
    chk("rst_ldr", ld_ready, 0);
    chk("rst_addr", mem_addr, 0);
    reset = 0;
    tick();
    go = 1;
    tick();
    go = 0;
    chk("go_prst", proc_reset, 1);
    chk("go_busy", busy, 1);
    tick();
    chk("prst2", proc_reset, 1);
    tick();
    chk("prst_done", proc_reset, 0);
    chk("ld_ready", ld_ready, 1);
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1; ld_addr = 8'(i); ld_data = exp_rb[i]; ld_last = (i == 2);
      #1;
      chk("ld_we", mem_we, 1);
      chk("ld_addr", mem_addr, i);
      chk("ld_wdata", mem_wdata, exp_rb[i]);
      tick();
    end
    ld_valid = 0; ld_last = 0;
    for (int k = 0; k < 4; k++) begin
      chk("start_hi", start, 1);
      tick();
    end
    chk("start_lo", start, 0);
    chk("lo_busy", busy, 1);
    for (int k = 0; k < 10; k++) begin
      if (k == 3) begin
        go = 1; ld_valid = 1;
        #1 chk("ld_ignored", mem_we, 0);
      end
      tick();
      go = 0; ld_valid = 0;
    end
    chk("go_ignored", busy, 1);
    chk("cycles10", cycles, 10);
    ack = 1;
    tick();
    for (int w = 0; w < 3; w++) begin
      chk("rb_addr", mem_addr, w);
      chk("rb_addr_novalid", rb_valid, 0);
      tick();
      chk("rb_valid", rb_valid, 1);
      chk("rb_data", rb_data, exp_rb[w]);
      if (w == 1) repeat (5) begin
        tick();
        chk("stall_valid", rb_valid, 1);
        chk("stall_data", rb_data, 8'h22);
      end
      rb_ready = 1;
      tick();
      rb_ready = 0;
    end
    chk("done", done, 1);
    chk("done_busy", busy, 0);
    chk("done_rbv", rb_valid, 0);
    chk("done_cycles", cycles, 10);
    chk("done_timeout", timeout, 0);
    launch();
    repeat (3) tick();
    ack = 1;
    tick();
    chk("cycles3", cycles, 3);
    tick();
    chk("abort_rbv", rb_valid, 1);
    chk("abort_data", rb_data, 8'h11);
    reset = 1;
    tick();
    reset = 0;
    chk("abort_busy", busy, 0);
    chk("abort_rbv0", rb_valid, 0);
    chk("abort_data0", rb_data, 0);
    chk("abort_cycles", cycles, 0);
    chk("abort_start", start, 0);
    chk("abort_prst", proc_reset, 0);
    launch();
    repeat (5) tick();
    ack = 1;
    tick();
    chk("cycles5", cycles, 5);
    rb_ready = 1;
    repeat (6) tick();
    rb_ready = 0;
    chk("run2_done", done, 1);
    chk("run2_last", rb_data, 8'h33);
    launch();
`ifdef HOST_LAUNCHER_WATCHDOG_EN
    repeat (19) tick();
    chk("wd_not_yet", timeout, 0);
    tick();
    chk("wd_timeout", timeout, 1);
    chk("wd_no_done", done, 0);
    chk("wd_no_rbv", rb_valid, 0);
    chk("wd_busy", busy, 0);
    launch();
    repeat (19) tick();
    ack = 1;
    tick();
    chk("wd_ack_wins", timeout, 0);
    chk("wd_ack_busy", busy, 1);
    rb_ready = 1;
    repeat (6) tick();
    rb_ready = 0;
    chk("wd_ack_done", done, 1);
    chk("wd_ack_to0", timeout, 0);
`else
    repeat (40) tick();
    chk("nowd_busy", busy, 1);
    chk("nowd_timeout", timeout, 0);
    chk("nowd_rbv", rb_valid, 0);
    chk("nowd_cycles", cycles, 40);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/host_launcher.md
# host_launcher

Host-side initiator for the processor's start/ack run handshake. It resets the processor, preloads data memory through a valid/ready load stream, and drives `start` high then low to launch a program. It then waits for the sticky `ack` while counting cycles, and streams a configurable window of data memory back out once the run completes. It sits between the bench or host logic and `top_level`, and is the driving end of the interface that `top_level` only responds to.

## Interface
Parameters:
- ADDR_W, 8, data-memory address width
- DATA_W, 8, data-memory word width
- START_PULSE, 4, cycles `start` is held high (≥1)
- RB_BASE, 0, first readback address
- RB_COUNT, 4, number of readback words (0 allowed)
- WDOG_LIMIT, 4096, wait-for-ack cycle limit (watchdog builds only)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- go  in  1  launch request; sampled only in IDLE, DONE, TIMEOUT
- ld_valid  in  1  load word valid
- ld_ready  out  1  load word accepted (LOAD state only)
- ld_addr  in  ADDR_W  load address
- ld_data  in  DATA_W  load data
- ld_last  in  1  marks final load word
- proc_reset  out  1  reset to processor
- start  out  1  processor start
- ack  in  1  processor done, sticky until proc_reset
- mem_we  out  1  data-memory write strobe
- mem_addr  out  ADDR_W  data-memory address
- mem_wdata  out  DATA_W  data-memory write data
- mem_rdata  in  DATA_W  data-memory read data, 1-cycle latency
- rb_valid  out  1  readback word valid
- rb_ready  in  1  readback consumer ready
- rb_data  out  DATA_W  readback word
- busy  out  1  high in every state except IDLE/DONE/TIMEOUT
- done  out  1  run completed with ack
- timeout  out  1  watchdog expired
- cycles  out  16  cycles from first `start`-low cycle to `ack` seen, saturating at 16'hFFFF

## Operation
- States: IDLE, PRST, LOAD, START_HI, START_LO, RB_ADDR, RB_HOLD, DONE, TIMEOUT.
- IDLE/DONE/TIMEOUT + go=1 → PRST. This clears done, timeout and cycles.
- PRST:
  - proc_reset=1 for exactly 2 cycles, then → LOAD.
- LOAD:
  - ld_ready=1.
  - On ld_valid: mem_we=1 with mem_addr=ld_addr and mem_wdata=ld_data in the same cycle (combinational pass-through).
  - ld_valid && ld_last → START_HI.
  - Zero-word load is not supported; at least one word with ld_last is required.
- START_HI:
  - start=1 for START_PULSE cycles, then → START_LO.
- START_LO:
  - start=0.
  - cycles increments each cycle ack=0.
  - ack=1 → RB_ADDR, or → DONE if RB_COUNT=0.
- RB_ADDR:
  - mem_addr=RB_BASE+i, where i is the word index starting at 0.
  - Address arithmetic wraps modulo 2^ADDR_W.
  - → RB_HOLD next cycle.
- RB_HOLD:
  - mem_rdata is captured into rb_data on entry.
  - rb_valid=1; rb_data stable until the rb_valid&&rb_ready transfer.
  - On transfer: i++ → RB_ADDR, or → DONE after word RB_COUNT-1.
- DONE: done=1, held until go or reset.
- TIMEOUT: timeout=1, held; no readback performed.
- go while busy is ignored. ld_valid outside LOAD is ignored.
- ack outside START_LO is ignored.

## Timing
- All outputs are registered except mem_we, mem_addr and mem_wdata in LOAD.
- Reset values:
  - state=IDLE.
  - proc_reset, start, mem_we, ld_ready, rb_valid, done, timeout = 0.
  - mem_addr, mem_wdata, rb_data = 0.
  - cycles=0.
  - busy=0.
- reset mid-run: abort immediately to IDLE with the values above. start drops the next edge; the processor is not reset by this block.
- go→proc_reset high: 1 cycle.
- Last load word → start high: 1 cycle.
- Each readback word takes at least 2 cycles.
- ack rise→done:
  - RB_COUNT=0: 1 cycle.
  - Otherwise: 2·RB_COUNT+1 cycles minimum.

## Configuration
- HOST_LAUNCHER_WATCHDOG_EN defined:
  - In START_LO, a wait counter reaching WDOG_LIMIT with ack=0 → TIMEOUT.
  - ack=1 on the same cycle the limit is reached wins, and the run → readback.
- HOST_LAUNCHER_WATCHDOG_EN undefined:
  - No watchdog; timeout is tied to 0 and START_LO waits indefinitely.
  - WDOG_LIMIT is unused.

## Structure
- host_launcher_pkg holds:
  - state enum `hl_state_t`.
  - CYC_W=16.
  - Default ADDR_W/DATA_W constants.
- Sub-module hl_watchdog: clear, enable, limit compare and expired flag.
  - Instantiated only under HOST_LAUNCHER_WATCHDOG_EN.

## Test plan
- Load 3 words (addr 0..2 = 8'h11, 8'h22, 8'h33; ld_last on 3rd) → 3 mem_we pulses with matching addr/data; start high 4 cycles then low.
- Responder raises ack 10 cycles after start falls, RB_BASE=0, RB_COUNT=3 → cycles=10; rb_data 8'h11, 8'h22, 8'h33 in order; done=1.
- rb_ready held 0 for 5 cycles on word 1 → rb_valid and rb_data stay stable; no word lost or duplicated.
- Watchdog build, WDOG_LIMIT=20, ack never rises → timeout=1 after 20 START_LO cycles; no rb_valid; done=0.
- Watchdog build, ack on exactly the limit cycle → done path taken; timeout=0.
- reset asserted in RB_HOLD, then go → outputs at reset values; the new run issues a 2-cycle proc_reset and cycles restarts from 0.
